// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Purpose: gives NUM_PORTS requesters round-robin access to one memory port.
// The port is made of a command channel, a write-data channel and a read-data
// channel. A grant covers one whole transaction, which is the command followed
// by all of its data words. Only one transaction is in flight at a time.
//
// Ports (each channel is a valid/ready pair; a word moves when enable && ready):
//   clk, reset                      clock; synchronous active-high reset
//   req_enable/ready/rnw/addr/len   per-port command request (packed per port)
//   wr_enable/ready/data            per-port write-word stream
//   rd_enable/ready, rd_data        per-port read-word stream (rd_data broadcast)
//   mem_cmd_enable/ready/data       command to memory {rnw, addr, len}
//   mem_wr_enable/ready/data        write words to memory
//   mem_rd_enable/ready/data        read words from memory
module mem_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int MEM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req_enable,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_rnw,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*LEN_WIDTH-1:0]  req_len,
  input  logic [NUM_PORTS-1:0]            wr_enable,
  output logic [NUM_PORTS-1:0]            wr_ready,
  input  logic [NUM_PORTS*MEM_WIDTH-1:0]  wr_data,
  output logic [NUM_PORTS-1:0]            rd_enable,
  input  logic [NUM_PORTS-1:0]            rd_ready,
  output logic [MEM_WIDTH-1:0]            rd_data,
  output logic                            mem_cmd_enable,
  input  logic                            mem_cmd_ready,
  output logic [ADDR_WIDTH+LEN_WIDTH:0]   mem_cmd_data,
  output logic                            mem_wr_enable,
  input  logic                            mem_wr_ready,
  output logic [MEM_WIDTH-1:0]            mem_wr_data,
  input  logic                            mem_rd_enable,
  output logic                            mem_rd_ready,
  input  logic [MEM_WIDTH-1:0]            mem_rd_data
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WDATA, ST_RDATA} state_t;

  state_t                 state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic                   rnw_q, rnw_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   count_q, count_d;

  logic                   arb_found;
  logic [IDX_W-1:0]       arb_idx;
  logic [IDX_W-1:0]       arb_cand;
  logic [NUM_PORTS-1:0]   arb_oh;
  logic                   sel_rnw;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [LEN_WIDTH-1:0]   sel_len;

  logic                   g_wr_enable;
  logic [MEM_WIDTH-1:0]   g_wr_data;
  logic                   g_rd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      rnw_q        <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rnw_q        <= rnw_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      count_q      <= count_d;
    end
  end

  // Round-robin search. Candidates are walked from lowest to highest priority,
  // so the last hit is the first requester after last_grant (with wrap).
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      arb_cand = IDX_W'((int'(last_grant_q) + k) % NUM_PORTS);
      if (req_enable[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
    arb_oh   = arb_found ? (NUM_PORTS'(1) << arb_idx) : '0;
    sel_rnw  = 1'b0;
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_oh[i]) begin
        sel_rnw  = req_rnw[i];
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // Data-path selection for the port that owns the current transaction.
  always_comb begin
    g_wr_enable = |(wr_enable & grant_q);
    g_rd_ready  = |(rd_ready & grant_q);
    g_wr_data   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) begin
        g_wr_data = wr_data[i*MEM_WIDTH +: MEM_WIDTH];
      end
    end
  end

  // Next state and outputs. All outputs are forced to 0 while reset is held,
  // so a reset in the middle of a transfer never exposes a stale handshake.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    rnw_d          = rnw_q;
    addr_d         = addr_q;
    len_d          = len_q;
    count_d        = count_q;
    req_ready      = '0;
    wr_ready       = '0;
    rd_enable      = '0;
    rd_data        = '0;
    mem_cmd_enable = 1'b0;
    mem_cmd_data   = '0;
    mem_wr_enable  = 1'b0;
    mem_wr_data    = '0;
    mem_rd_ready   = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (arb_found) begin
            req_ready    = arb_oh;
            last_grant_d = arb_idx;
            grant_d      = arb_oh;
            rnw_d        = sel_rnw;
            addr_d       = sel_addr;
            len_d        = sel_len;
            count_d      = '0;
            // A zero-length request is consumed here and never reaches memory.
            if (sel_len != '0) begin
              state_d = ST_CMD;
            end
          end
        end
        ST_CMD: begin
          mem_cmd_enable = 1'b1;
          mem_cmd_data   = {rnw_q, addr_q, len_q};
          if (mem_cmd_ready) begin
            count_d = '0;
            state_d = rnw_q ? ST_RDATA : ST_WDATA;
          end
        end
        ST_WDATA: begin
          mem_wr_enable = g_wr_enable;
          mem_wr_data   = g_wr_data;
          wr_ready      = grant_q & {NUM_PORTS{mem_wr_ready}};
          if (g_wr_enable && mem_wr_ready) begin
            if (count_q == len_q - LEN_WIDTH'(1)) begin
              count_d = '0;
              state_d = ST_IDLE;
            end else begin
              count_d = count_q + LEN_WIDTH'(1);
            end
          end
        end
        ST_RDATA: begin
          rd_enable    = grant_q & {NUM_PORTS{mem_rd_enable}};
          rd_data      = mem_rd_data;
          mem_rd_ready = g_rd_ready;
          if (mem_rd_enable && g_rd_ready) begin
            if (count_q == len_q - LEN_WIDTH'(1)) begin
              count_d = '0;
              state_d = ST_IDLE;
            end else begin
              count_d = count_q + LEN_WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Purpose: directed self-checking bench for mem_arbiter (4 ports, 32-bit
// fields). The bench plays both the requesters and the memory.
module tb_mem_arbiter;

  localparam int NP = 4;
  localparam int MW = 32;
  localparam int AW = 32;
  localparam int LW = 32;

  logic              tb_host_clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     req_enable, req_ready, req_rnw;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*LW-1:0]  req_len;
  logic [NP-1:0]     wr_enable, wr_ready;
  logic [NP*MW-1:0]  wr_data;
  logic [NP-1:0]     rd_enable, rd_ready;
  logic [MW-1:0]     rd_data;
  logic              mem_cmd_enable, mem_cmd_ready;
  logic [AW+LW:0]    mem_cmd_data;
  logic              mem_wr_enable, mem_wr_ready;
  logic [MW-1:0]     mem_wr_data;
  logic              mem_rd_enable, mem_rd_ready;
  logic [MW-1:0]     mem_rd_data;

  int checks = 0;
  int errors = 0;

  logic [AW+LW:0]    exp_cmd;
  logic [NP-1:0]     exp_order [6];
  int                exp_port  [6];

  mem_arbiter #(.NUM_PORTS(NP), .MEM_WIDTH(MW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(tb_host_clk), .reset(reset),
    .req_enable(req_enable), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_len(req_len),
    .wr_enable(wr_enable), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_enable(rd_enable), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_cmd_enable(mem_cmd_enable), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_data(mem_cmd_data),
    .mem_wr_enable(mem_wr_enable), .mem_wr_ready(mem_wr_ready), .mem_wr_data(mem_wr_data),
    .mem_rd_enable(mem_rd_enable), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data)
  );

  always #5 tb_host_clk = ~tb_host_clk;

  task automatic check_output(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge tb_host_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int p, input logic rnw, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    req_rnw[p]             = rnw;
    req_addr[p*AW +: AW]   = addr;
    req_len[p*LW +: LW]    = len;
  endtask

  task automatic clear_inputs();
    req_enable    = '0;
    req_rnw       = '0;
    req_addr      = '0;
    req_len       = '0;
    wr_enable     = '0;
    wr_data       = '0;
    rd_ready      = '0;
    mem_cmd_ready = 1'b0;
    mem_wr_ready  = 1'b0;
    mem_rd_enable = 1'b0;
    mem_rd_data   = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence ended");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    int w;
    logic pat;
    reset = 1'b0;
    clear_inputs();
    apply_reset();

    // Reset state: everything quiet
    settle();
    check_output("reset_req_ready", req_ready, 0);
    check_output("reset_cmd_enable", mem_cmd_enable, 0);
    check_output("reset_cmd_data", mem_cmd_data, 0);
    check_output("reset_wr_enable", mem_wr_enable, 0);
    check_output("reset_rd_ready", mem_rd_ready, 0);

    // Test 1: port 1 write 0x100 len 4, with one memory stall
    $display("[TB] test 1: port 1 write");
    set_req(1, 1'b0, 32'h100, 32'd4);
    req_enable = 4'b0010;
    settle();
    check_output("t1_req_ready", req_ready, 4'b0010);
    next_cycle();
    req_enable    = '0;
    mem_cmd_ready = 1'b1;
    settle();
    exp_cmd = {1'b0, 32'h100, 32'd4};
    check_output("t1_cmd_enable", mem_cmd_enable, 1);
    check_output("t1_cmd_data", mem_cmd_data, exp_cmd);
    check_output("t1_wr_ready_in_cmd", wr_ready, 0);
    next_cycle();
    mem_cmd_ready = 1'b0;
    wr_enable     = 4'b0010;
    k = 0;
    for (int s = 0; s < 5; s++) begin
      mem_wr_ready    = (s != 2);
      wr_data[1*MW +: MW] = 32'hA0 + k;
      settle();
      check_output($sformatf("t1_wr_ready_s%0d", s), wr_ready, (s != 2) ? 4'b0010 : 4'b0000);
      check_output($sformatf("t1_wr_data_s%0d", s), mem_wr_data, 32'hA0 + k);
      check_output($sformatf("t1_wr_enable_s%0d", s), mem_wr_enable, 1);
      next_cycle();
      if (s != 2) k++;
    end
    mem_wr_ready = 1'b1;
    settle();
    check_output("t1_idle_wr_ready", wr_ready, 0);
    check_output("t1_idle_wr_enable", mem_wr_enable, 0);
    wr_enable    = '0;
    mem_wr_ready = 1'b0;

    // Test 2: ports 0,2,3 contend; round robin from a fresh reset
    $display("[TB] test 2: round robin");
    apply_reset();
    exp_order = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
    exp_port  = '{0, 2, 3, 0, 2, 3};
    for (int p = 0; p < NP; p++) begin
      set_req(p, 1'b0, 32'h1000 + p, 32'd1);
      wr_data[p*MW +: MW] = 32'hD0 + p;
    end
    req_enable = 4'b1101;
    for (int n = 0; n < 6; n++) begin
      settle();
      check_output($sformatf("t2_grant%0d", n), req_ready, exp_order[n]);
      next_cycle();
      mem_cmd_ready = 1'b1;
      settle();
      exp_cmd = {1'b0, 32'h1000 + exp_port[n], 32'd1};
      check_output($sformatf("t2_cmd%0d", n), mem_cmd_data, exp_cmd);
      next_cycle();
      mem_cmd_ready = 1'b0;
      wr_enable     = 4'b1111;
      mem_wr_ready  = 1'b1;
      settle();
      check_output($sformatf("t2_wr_ready%0d", n), wr_ready, exp_order[n]);
      check_output($sformatf("t2_wr_data%0d", n), mem_wr_data, 32'hD0 + exp_port[n]);
      next_cycle();
      wr_enable    = '0;
      mem_wr_ready = 1'b0;
    end
    req_enable = '0;

    // Test 3: port 3 read 0x20 len 3 with rd_ready toggling
    $display("[TB] test 3: port 3 read");
    set_req(3, 1'b1, 32'h20, 32'd3);
    req_enable = 4'b1000;
    settle();
    check_output("t3_req_ready", req_ready, 4'b1000);
    next_cycle();
    req_enable    = '0;
    mem_rd_enable = 1'b1;
    mem_rd_data   = 32'hB0;
    rd_ready      = 4'b1000;
    settle();
    exp_cmd = {1'b1, 32'h20, 32'd3};
    check_output("t3_cmd_data", mem_cmd_data, exp_cmd);
    check_output("t3_rd_ready_in_cmd", mem_rd_ready, 0);
    check_output("t3_rd_enable_in_cmd", rd_enable, 0);
    mem_cmd_ready = 1'b1;
    next_cycle();
    mem_cmd_ready = 1'b0;
    w = 0;
    for (int s = 0; s < 5; s++) begin
      pat         = (s % 2 == 0);
      rd_ready    = pat ? 4'b1000 : 4'b0111;
      mem_rd_data = 32'hB0 + w;
      settle();
      check_output($sformatf("t3_rd_enable_s%0d", s), rd_enable, 4'b1000);
      check_output($sformatf("t3_mem_rd_ready_s%0d", s), mem_rd_ready, pat);
      check_output($sformatf("t3_rd_data_s%0d", s), rd_data, 32'hB0 + w);
      next_cycle();
      if (pat) w++;
    end
    mem_rd_data = 32'hB3;
    rd_ready    = 4'b1000;
    settle();
    check_output("t3_idle_mem_rd_ready", mem_rd_ready, 0);
    check_output("t3_idle_rd_enable", rd_enable, 0);
    check_output("t3_idle_rd_data", rd_data, 0);
    mem_rd_enable = 1'b0;
    rd_ready      = '0;

    // Tests 4 and 5: port 0 len 0 dropped, port 1 len 2 with a stalled command
    $display("[TB] test 4/5: zero length and command stall");
    set_req(0, 1'b0, 32'h200, 32'd0);
    set_req(1, 1'b0, 32'h300, 32'd2);
    req_enable = 4'b0011;
    settle();
    check_output("t4_grant_p0", req_ready, 4'b0001);
    next_cycle();
    req_enable = 4'b0010;
    settle();
    check_output("t4_no_cmd_for_p0", mem_cmd_enable, 0);
    check_output("t4_grant_p1", req_ready, 4'b0010);
    next_cycle();
    req_enable   = '0;
    wr_enable    = 4'b0010;
    wr_data[1*MW +: MW] = 32'hC0;
    mem_wr_ready = 1'b1;
    exp_cmd = {1'b0, 32'h300, 32'd2};
    for (int s = 0; s < 10; s++) begin
      settle();
      check_output($sformatf("t5_cmd_enable_s%0d", s), mem_cmd_enable, 1);
      check_output($sformatf("t5_cmd_data_s%0d", s), mem_cmd_data, exp_cmd);
      check_output($sformatf("t5_wr_ready_s%0d", s), wr_ready, 0);
      next_cycle();
    end
    mem_cmd_ready = 1'b1;
    next_cycle();
    mem_cmd_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      wr_data[1*MW +: MW] = 32'hC0 + s;
      settle();
      check_output($sformatf("t5_wr_ready_w%0d", s), wr_ready, 4'b0010);
      check_output($sformatf("t5_wr_data_w%0d", s), mem_wr_data, 32'hC0 + s);
      next_cycle();
    end
    settle();
    check_output("t5_idle_wr_ready", wr_ready, 0);
    wr_enable    = '0;
    mem_wr_ready = 1'b0;

    // Test 6: reset after 2 of 5 words, then priority restarts at port 0
    $display("[TB] test 6: reset mid-transfer");
    set_req(1, 1'b0, 32'h400, 32'd5);
    req_enable = 4'b0010;
    settle();
    check_output("t6_grant_p1", req_ready, 4'b0010);
    next_cycle();
    req_enable    = '0;
    mem_cmd_ready = 1'b1;
    next_cycle();
    mem_cmd_ready = 1'b0;
    wr_enable     = 4'b0010;
    mem_wr_ready  = 1'b1;
    for (int s = 0; s < 2; s++) begin
      wr_data[1*MW +: MW] = 32'hE0 + s;
      settle();
      check_output($sformatf("t6_wr_data_w%0d", s), mem_wr_data, 32'hE0 + s);
      next_cycle();
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    settle();
    check_output("t6_rst_wr_ready", wr_ready, 0);
    check_output("t6_rst_wr_enable", mem_wr_enable, 0);
    check_output("t6_rst_wr_data", mem_wr_data, 0);
    check_output("t6_rst_cmd_enable", mem_cmd_enable, 0);
    check_output("t6_rst_rd_enable", rd_enable, 0);
    wr_enable    = '0;
    mem_wr_ready = 1'b0;
    set_req(0, 1'b0, 32'h500, 32'd0);
    set_req(2, 1'b0, 32'h600, 32'd1);
    req_enable = 4'b0101;
    settle();
    check_output("t6_grant_p0_first", req_ready, 4'b0001);
    next_cycle();
    req_enable = 4'b0100;
    settle();
    check_output("t6_grant_p2", req_ready, 4'b0100);
    next_cycle();
    req_enable    = '0;
    mem_cmd_ready = 1'b1;
    settle();
    exp_cmd = {1'b0, 32'h600, 32'd1};
    check_output("t6_cmd_data_p2", mem_cmd_data, exp_cmd);
    next_cycle();
    mem_cmd_ready = 1'b0;
    wr_enable     = 4'b0100;
    wr_data[2*MW +: MW] = 32'hF2;
    mem_wr_ready  = 1'b1;
    settle();
    check_output("t6_wr_ready_p2", wr_ready, 4'b0100);
    check_output("t6_wr_data_p2", mem_wr_data, 32'hF2);
    next_cycle();
    clear_inputs();
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
